reg_bus_master: RTL

//  Initiator side of the register-file bus (WEN/OEN/ADDR/DIN/DOUT).

---
 rtl/reg_bus_master.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/reg_bus_master.sv
// Register-file bus initiator: takes one host command at a time over valid/ready,
// runs the WEN/OEN bus cycle and returns exactly one response per command.
module reg_bus_master #(
  parameter int unsigned N_REGS = 7,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  output logic              bus_wen,
  output logic              bus_oen,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W:0]   bus_din,
  input  logic [DATA_W:0]   bus_dout,
  output logic [CNT_W-1:0]  txn_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              accept_c;
  logic              addr_ok_c;
  logic              rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              bus_wen_d, bus_oen_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W:0]   bus_din_d;
  logic [CNT_W-1:0]  txn_cnt_d;
  logic              dout_msb_unused;

  // The register file's extra data bit carries no information.
  assign dout_msb_unused = bus_dout[DATA_W];

  assign cmd_ready = (state_q == IDLE) && rst_n;
  assign accept_c  = cmd_valid && cmd_ready;
  assign addr_ok_c = 32'(cmd_addr) < N_REGS;

  // Next state and next registered outputs; bus strobes are set on entry to WR/RD
  // so they are high for exactly the one cycle spent in that state.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_data_d  = rsp_data;
    bus_wen_d   = 1'b0;
    bus_oen_d   = 1'b0;
    bus_addr_d  = '0;
    bus_din_d   = '0;
    txn_cnt_d   = txn_cnt;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = '0;
          if (!addr_ok_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (cmd_write) begin
            state_d    = WR;
            bus_wen_d  = 1'b1;
            bus_addr_d = cmd_addr;
            bus_din_d  = {1'b0, cmd_wdata};
          end else begin
            state_d    = RD;
            bus_oen_d  = 1'b1;
            bus_addr_d = cmd_addr;
          end
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        txn_cnt_d   = txn_cnt + CNT_W'(1);
      end
      RD: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus_dout[DATA_W-1:0];
        txn_cnt_d   = txn_cnt + CNT_W'(1);
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight command silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      bus_wen   <= 1'b0;
      bus_oen   <= 1'b0;
      bus_addr  <= '0;
      bus_din   <= '0;
      txn_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_data  <= rsp_data_d;
      bus_wen   <= bus_wen_d;
      bus_oen   <= bus_oen_d;
      bus_addr  <= bus_addr_d;
      bus_din   <= bus_din_d;
      txn_cnt   <= txn_cnt_d;
    end
  end

endmodule
